// File: rtl/matvec_operand_loader.sv
// Stream-to-parallel operand loader for matrix_vector_prod_seq.
// Collects header, optional 4x4 matrix and 4-element vector, then holds them until the product stage takes them.
module matvec_operand_loader #(
  parameter int DATA_W = 32,
  parameter int N      = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_W-1:0]         i_data,
  input  logic                      i_valid,
  output logic                      i_ready,
  output logic [N*N*DATA_W-1:0]     o_matrix,
  output logic [N*DATA_W-1:0]       o_vector,
  output logic                      o_valid,
  input  logic                      o_ready,
  output logic                      o_mat_loaded,
  output logic [1:0]                dbg_state,
  output logic [3:0]                dbg_cnt
);

  // Handshakes: a word moves when i_valid && i_ready at a rising edge; operands
  // move when o_valid && o_ready. o_valid never drops without a handshake and
  // o_matrix/o_vector do not change while o_valid is high.

  localparam int MAT_WORDS = N * N;
  localparam logic [3:0] MAT_LAST = 4'(MAT_WORDS - 1);
  localparam logic [3:0] VEC_LAST = 4'(N - 1);

  typedef enum logic [1:0] {
    HEADER  = 2'd0,
    MATRIX  = 2'd1,
    VECTOR  = 2'd2,
    PRESENT = 2'd3
  } state_t;

  state_t                   state;
  logic [3:0]               cnt;
  logic [MAT_WORDS*DATA_W-1:0] mat_q;
  logic [N*DATA_W-1:0]      vec_q;
  logic                     valid_q;
  logic                     loaded_q;
  logic                     xfer;

  // Ready depends only on state and reset, never on i_valid or o_ready.
  assign i_ready = rst && (state != PRESENT);
  assign xfer    = i_valid && i_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= HEADER;
      cnt      <= 4'd0;
      mat_q    <= '0;
      vec_q    <= '0;
      valid_q  <= 1'b0;
      loaded_q <= 1'b0;
    end else begin
      case (state)
        HEADER: begin
          if (xfer) begin
            cnt   <= 4'd0;
            state <= i_data[0] ? MATRIX : VECTOR;
          end
        end
        MATRIX: begin
          if (xfer) begin
            mat_q[cnt*DATA_W +: DATA_W] <= i_data;
            if (cnt == MAT_LAST) begin
              cnt      <= 4'd0;
              loaded_q <= 1'b1;
              state    <= VECTOR;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end
        VECTOR: begin
          if (xfer) begin
            vec_q[cnt[1:0]*DATA_W +: DATA_W] <= i_data;
            if (cnt == VEC_LAST) begin
              valid_q <= 1'b1;
              state   <= PRESENT;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end
        PRESENT: begin
          if (o_ready) begin
            valid_q <= 1'b0;
            state   <= HEADER;
          end
        end
        default: state <= HEADER;
      endcase
    end
  end

  assign o_matrix     = mat_q;
  assign o_vector     = vec_q;
  assign o_valid      = valid_q;
  assign o_mat_loaded = loaded_q;
  assign dbg_state    = state;
  assign dbg_cnt      = cnt;

endmodule

// File: tb/tb_matvec_operand_loader.sv
// Bench for matvec_operand_loader: frame driver, reference operand model and scoreboard monitor.
module tb_matvec_operand_loader;

  localparam int DW = 32;
  localparam int MW = 16 * DW;
  localparam int VW = 4 * DW;
  localparam int W  = 1 + MW + VW;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] i_data;
  logic          i_valid;
  logic          i_ready;
  logic [MW-1:0] o_matrix;
  logic [VW-1:0] o_vector;
  logic          o_valid;
  logic          o_ready;
  logic          o_mat_loaded;
  logic [1:0]    dbg_state;
  logic [3:0]    dbg_cnt;

  matvec_operand_loader #(.DATA_W(DW), .N(4)) dut (
    .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid), .i_ready(i_ready),
    .o_matrix(o_matrix), .o_vector(o_vector), .o_valid(o_valid), .o_ready(o_ready),
    .o_mat_loaded(o_mat_loaded), .dbg_state(dbg_state), .dbg_cnt(dbg_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  logic [W-1:0] exp_q[$];

  // Reference model: the matrix last loaded since reset and whether one exists.
  logic [MW-1:0] model_mat;
  logic          model_loaded;

  task automatic chk(input bit ok, input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (ok) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_word(input logic [DW-1:0] w, input int gap_pct);
    int tmo;
    while (int'($urandom_range(99)) < gap_pct) begin
      i_valid = 1'b0;
      i_data  = $urandom;
      tick();
    end
    i_data  = w;
    i_valid = 1'b1;
    tmo = 0;
    @(negedge clk);
    while (!i_ready && tmo < 200) begin
      @(negedge clk);
      tmo++;
    end
    if (!i_ready) chk(1'b0, "word_accept_timeout", W'(0), W'(1));
    tick();
    i_valid = 1'b0;
  endtask

  task automatic send_frame(input bit load, input logic [MW-1:0] mat, input logic [VW-1:0] vec,
                            input int gap_pct);
    if (load) begin
      model_mat    = mat;
      model_loaded = 1'b1;
    end
    exp_q.push_back({model_loaded, model_mat, vec});
    send_word({$urandom_range(32'h7fff_ffff), load}, gap_pct);
    if (load) for (int i = 0; i < 16; i++) send_word(mat[i*DW +: DW], gap_pct);
    for (int k = 0; k < 4; k++) send_word(vec[k*DW +: DW], gap_pct);
    chk(o_valid === 1'b1, "valid_on_last_word", W'(o_valid), W'(1));
  endtask

  task automatic wait_drain();
    int tmo = 0;
    while (exp_q.size() != 0 && tmo < 500) begin
      tick();
      tmo++;
    end
    chk(exp_q.size() == 0, "drain_timeout", W'(exp_q.size()), W'(0));
  endtask

  // Output monitor: pops the scoreboard on every operand handshake.
  bit            mon_en = 1'b0;
  bit            prev_hs = 1'b0;
  bit            prev_hold = 1'b0;
  logic [MW-1:0] held_mat;
  logic [VW-1:0] held_vec;
  logic [W-1:0]  exp_e;

  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_hs) begin
        chk(o_valid === 1'b0, "valid_one_cycle", W'(o_valid), W'(0));
        chk(i_ready === 1'b1, "ready_after_handshake", W'(i_ready), W'(1));
      end
      if (prev_hold)
        chk(o_valid === 1'b1 && o_matrix === held_mat && o_vector === held_vec, "hold_stable",
            {o_valid, o_matrix, o_vector}, {1'b1, held_mat, held_vec});
      if (o_valid === 1'b1) begin
        chk(i_ready === 1'b0, "ready_low_present", W'(i_ready), W'(0));
        if (o_ready) begin
          if (exp_q.size() == 0) chk(1'b0, "unexpected_output", {o_mat_loaded, o_matrix, o_vector}, W'(0));
          else begin
            exp_e = exp_q.pop_front();
            chk({o_mat_loaded, o_matrix, o_vector} === exp_e, "operands",
                {o_mat_loaded, o_matrix, o_vector}, exp_e);
          end
        end
      end
      prev_hs   = (o_valid === 1'b1) && o_ready && rst;
      prev_hold = (o_valid === 1'b1) && !o_ready && rst;
      held_mat  = o_matrix;
      held_vec  = o_vector;
    end
  end

  // Idle cycles must not move the counter or the state.
  always @(posedge clk) begin
    logic v, r;
    logic [3:0] c;
    logic [1:0] s;
    v = i_valid; r = rst; c = dbg_cnt; s = dbg_state;
    #1;
    if (mon_en && r && !v && s != 2'd3)
      chk(dbg_cnt === c && dbg_state === s, "idle_no_advance", W'({dbg_state, dbg_cnt}), W'({s, c}));
  end

  logic [MW-1:0] ident, rmat;
  logic [VW-1:0] vec1, vec5, rvec;

  initial begin
    ident = '0;
    for (int i = 0; i < 4; i++) ident[(i*4+i)*DW +: DW] = 32'h3F80_0000;
    vec1 = {32'h4080_0000, 32'h4040_0000, 32'h4000_0000, 32'h3F80_0000};
    vec5 = {4{32'h40A0_0000}};
    model_mat = '0;
    model_loaded = 1'b0;

    // Reset with input asserted.
    rst = 1'b0; i_valid = 1'b1; i_data = 32'hFFFF_FFFF; o_ready = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk(i_ready === 1'b0, "rst_i_ready", W'(i_ready), W'(0));
    chk(o_valid === 1'b0, "rst_o_valid", W'(o_valid), W'(0));
    chk(o_mat_loaded === 1'b0, "rst_mat_loaded", W'(o_mat_loaded), W'(0));
    chk(o_matrix === '0 && o_vector === '0, "rst_operands", W'({o_matrix, o_vector}), W'(0));
    @(posedge clk); #1;
    rst = 1'b1; i_valid = 1'b0;
    @(negedge clk);
    chk(i_ready === 1'b1, "ready_after_reset", W'(i_ready), W'(1));
    tick();
    mon_en = 1'b1;

    // Identity matrix frame, then vector-only follow-on.
    send_frame(1'b1, ident, vec1, 0);
    wait_drain();
    send_frame(1'b0, ident, vec5, 0);
    wait_drain();

    // Backpressure for 6 cycles.
    o_ready = 1'b0;
    send_frame(1'b0, ident, vec1, 0);
    repeat (6) tick();
    o_ready = 1'b1;
    wait_drain();

    // Gapped full frame.
    send_frame(1'b1, ident, vec1, 50);
    wait_drain();

    // Reset after matrix word 7 of a load frame.
    rmat = {16{$urandom}};
    send_word(32'h1, 0);
    for (int i = 0; i < 8; i++) send_word($urandom, 0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    model_mat = '0;
    model_loaded = 1'b0;
    @(negedge clk);
    chk(o_matrix === '0 && o_vector === '0, "midframe_rst_regs", W'({o_matrix, o_vector}), W'(0));
    chk(o_mat_loaded === 1'b0, "midframe_rst_loaded", W'(o_mat_loaded), W'(0));
    chk(dbg_state === 2'd0 && dbg_cnt === 4'd0, "midframe_rst_state", W'({dbg_state, dbg_cnt}), W'(0));
    tick();

    // Vector-only before any load uses the zero matrix.
    rvec = {$urandom, $urandom, $urandom, $urandom};
    send_frame(1'b0, rmat, rvec, 0);
    wait_drain();
    for (int i = 0; i < 16; i++) rmat[i*DW +: DW] = $urandom;
    send_frame(1'b1, rmat, vec1, 0);
    wait_drain();

    // Random frames with random gaps and backpressure.
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < 16; i++) rmat[i*DW +: DW] = $urandom;
      for (int k = 0; k < 4; k++) rvec[k*DW +: DW] = $urandom;
      o_ready = 1'($urandom_range(1));
      send_frame(1'($urandom_range(1)), rmat, rvec, int'($urandom_range(60)));
      repeat ($urandom_range(4)) tick();
      o_ready = 1'b1;
      wait_drain();
    end

    repeat (3) tick();
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
